// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the button debounce scheduler.
package debounce_pkg;

  localparam int N_BTN_DEF      = 4;
  localparam int TICK_DIV_DEF   = 16;
  localparam int STABLE_CNT_DEF = 4;

  // Scan FSM: wait for a prescaler tick, then walk every button once.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw button level.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two-stage capture; output lags din by two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one shared compare/update path visits each
// button once per prescaler period and accepts a new level only after
// STABLE_CNT consecutive disagreeing scans.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] result,
  output logic [N_BTN-1:0] press,
  // release pulses; 'release' is a reserved word, hence the short name
  output logic [N_BTN-1:0] rel,
  output logic             busy
);

  localparam int              PW       = cw(TICK_DIV);
  localparam int              IW       = cw(N_BTN);
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(N_BTN - 1);
  localparam logic [3:0]      STABLE   = 4'(STABLE_CNT);

  logic [N_BTN-1:0]      sync;
  logic [PW-1:0]         pre;
  logic                  tick;
  state_t                state;
  logic [IW-1:0]         idx;
  logic [N_BTN-1:0][3:0] cnt;

  logic       s_bit;
  logic       r_bit;
  logic       differ;
  logic [3:0] c_inc;
  logic       accept;

  // One synchronizer per button.
  btn_sync u_sync [N_BTN-1:0] (
    .clk  (clk),
    .rst  (rst),
    .din  (button),
    .dout (sync)
  );

  assign tick = (pre == PRE_MAX);

  // Free-running scan prescaler, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Shared compare path for the button selected by idx.
  always_comb begin
    s_bit  = sync[idx];
    r_bit  = result[idx];
    differ = s_bit ^ r_bit;
    c_inc  = cnt[idx] + 4'd1;
    accept = (state == SCAN) && differ && (c_inc == STABLE);
  end

  // Scan FSM plus per-button count/result update; pulses last one cycle
  // and coincide with the first cycle the new result is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      result <= '0;
      press  <= '0;
      rel    <= '0;
      cnt    <= '0;
    end else begin
      press <= '0;
      rel   <= '0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (accept) begin
            result[idx] <= ~r_bit;
            press[idx]  <= ~r_bit;
            rel[idx]    <= r_bit;
            cnt[idx]    <= '0;
          end else if (differ) begin
            cnt[idx] <= c_inc;
          end else begin
            cnt[idx] <= '0;
          end
          if (idx == IDX_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: an edge-numbered behavioural model is
// compared every cycle, with literal expectations pinning key cycles.
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int TD = 16;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] button = '0;
  logic [N-1:0] result, press, rel;
  logic         busy;

  always #5 clk = ~clk;

  debounce_scheduler #(.N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .result (result),
    .press  (press),
    .rel    (rel),
    .busy   (busy)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, m_e, $time);
  endtask

  // Model: m_e numbers rising edges since reset release (0 = first edge
  // with rst low). Button i is examined at edge e when e>=TD and
  // e%TD==i, using the level applied two edges earlier.
  int           m_e = -1;
  logic [N-1:0] m_res = '0, m_press = '0, m_rel = '0, h1 = '0, h2 = '0;
  int           m_cnt [N];
  logic         m_busy = 1'b0;
  bit           live = 1'b0;

  always @(posedge clk) begin : model
    int i;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_e = -1; m_res = '0; h1 = '0; h2 = '0; m_busy = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      m_e++;
      if (m_e >= TD && (m_e % TD) < N) begin
        i = m_e % TD;
        if (h2[i] != m_res[i]) begin
          if (m_cnt[i] + 1 == SC) begin
            m_res[i] = ~m_res[i];
            m_cnt[i] = 0;
            if (m_res[i]) m_press[i] = 1'b1;
            else          m_rel[i]   = 1'b1;
          end else m_cnt[i]++;
        end else m_cnt[i] = 0;
      end
      m_busy = ((m_e + 1) >= TD) && (((m_e + 1) % TD) < N);
      h2 = h1;
      h1 = button;
    end
    live = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      check("result", 32'(result), 32'(m_res));
      check("press",  32'(press),  32'(m_press));
      check("rel",    32'(rel),    32'(m_rel));
      check("busy",   32'(busy),   32'(m_busy));
    end
  end

  task automatic goto(input int e);
    int k = 0;
    while (m_e != e && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (m_e != e) begin
      n_tot++;
      $display("FAIL goto: edge %0d not reached (model at %0d)", e, m_e);
    end
  endtask

  task automatic do_reset(input logic [N-1:0] b);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_pulses", 32'({press, rel}), 32'h0);
    rst    = 1'b0;
    button = b;
  endtask

  initial begin
    // Single button held high; edge 64 is its fourth differing scan.
    do_reset(4'b0001);
    goto(14);  check("A_busy14",  32'(busy), 32'h0);
    goto(15);  check("A_busy15",  32'(busy), 32'h1);
    goto(18);  check("A_busy18",  32'(busy), 32'h1);
    goto(19);  check("A_busy19",  32'(busy), 32'h0);
    goto(63);  check("A_res63",   32'(result), 32'h0);
    goto(64);  check("A_res64",   32'(result), 32'h1);
               check("A_press64", 32'(press),  32'h1);
    goto(65);  check("A_press65", 32'(press),  32'h0);

    // Short 40-cycle press never reaches four scans.
    do_reset(4'b0010);
    goto(39);  button = 4'b0000;
    goto(100); check("B_res", 32'(result), 32'h0);

    // All buttons: accepted in consecutive cycles, index order.
    do_reset(4'b1111);
    goto(64);  check("C_res64",   32'(result), 32'h1);
    goto(65);  check("C_res65",   32'(result), 32'h3);
    goto(66);  check("C_res66",   32'(result), 32'h7);
               check("C_press66", 32'(press),  32'h4);
    goto(67);  check("C_res67",   32'(result), 32'hF);

    // Release of button 2, interrupted by a one-scan return to 1.
    goto(70);  button = 4'b1011;
    goto(120); button = 4'b1111;
    goto(130); check("D_res130", 32'(result), 32'hF);
    goto(131); button = 4'b1011;
    goto(193); check("D_res193", 32'(result), 32'hF);
    goto(194); check("D_res194", 32'(result), 32'hB);
               check("D_rel194", 32'(rel),    32'h4);
    goto(195); check("D_rel195", 32'(rel),    32'h0);

    // Reset in the middle of a scan.
    do_reset(4'b1111);
    goto(65);  check("E_res65", 32'(result), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("E_res_rst",   32'(result), 32'h0);
    check("E_press_rst", 32'(press),  32'h0);
    check("E_busy_rst",  32'(busy),   32'h0);
    rst = 1'b0;
    goto(14);  check("E_busy14", 32'(busy), 32'h0);
    goto(15);  check("E_busy15", 32'(busy), 32'h1);

    // Random bouncing with stable stretches, checked by the model only.
    do_reset(4'b0000);
    for (int blk = 0; blk < 24; blk++) begin
      int hold;
      hold = $urandom_range(1, 80);
      button = N'($urandom_range(0, 15));
      repeat (hold) @(negedge clk);
    end
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
